// File: rtl/lut_arb_pkg.sv
// Shared constants and the response tag type for the coefficient LUT arbiter.
package lut_arb_pkg;

  localparam int LUT_DEPTH      = 3072;
  localparam int LUT_ADDR_WIDTH = 12;
  localparam int LUT_READ_LAT   = 2;
  localparam int LUT_DATA_WIDTH = 32;
  localparam int LUT_NUM_REQ    = 4;
  localparam int LUT_ID_WIDTH   = 2;

  // One entry per accepted read, travelling alongside the RAM access.
  typedef struct packed {
    logic                    valid;
    logic [LUT_ID_WIDTH-1:0] id;
    logic                    oor;
  } rsp_tag_t;

endpackage

// File: rtl/lut_access_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner only when a grant is issued.
module rr_arbiter_n #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_id
);

  logic [ID_WIDTH-1:0] ptr;

  // Search from the pointer, wrapping, for the first active request.
  always_comb begin
    int   idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_WIDTH'(idx);
      end
    end
  end

  // Pointer advances to winner+1; held on idle and disabled cycles.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (|gnt)
      ptr <= (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

endmodule

// File: rtl/lut_access_arbiter.sv
// Shares one single-port coefficient LUT RAM between NUM_REQ read requesters
// and a host write port. Writes win outright; reads rotate round-robin.
// Optional statistics counters are built when LUT_ARB_STATS_EN is defined.
module lut_access_arbiter
  import lut_arb_pkg::*;
#(
  parameter int NUM_REQ    = LUT_NUM_REQ,
  parameter int ID_WIDTH   = LUT_ID_WIDTH,
  parameter int DEPTH      = LUT_DEPTH,
  parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
  parameter int READ_LAT   = LUT_READ_LAT
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wr_valid,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [LUT_DATA_WIDTH-1:0]     wr_data,
  output logic                          wr_ready,
  output logic [ADDR_WIDTH-1:0]         ram_address,
  output logic [LUT_DATA_WIDTH-1:0]     ram_data,
  output logic                          ram_rden,
  output logic                          ram_wren,
  input  logic [LUT_DATA_WIDTH-1:0]     ram_q,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [LUT_DATA_WIDTH-1:0]     rsp_data,
  output logic                          rsp_oor
`ifdef LUT_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [31:0]                   stat_rd_cnt,
  output logic [31:0]                   stat_wr_cnt,
  output logic [31:0]                   stat_stall_cnt
`endif
);

  localparam int TAG_DEPTH = READ_LAT + 1;

  logic [NUM_REQ-1:0]    gnt;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic                  rd_fire;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_oor;
  logic                  wr_oor;
  rsp_tag_t              tag_in;
  rsp_tag_t              tag_q [TAG_DEPTH];

  rr_arbiter_n #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .clock  (clock),
    .rst_n  (rst_n),
    .en     (!wr_valid),
    .req    (req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Handshakes and the selected read address, all combinational from valid.
  always_comb begin
    req_ready = gnt;
    wr_ready  = wr_valid;
    rd_fire   = |gnt;
    rd_addr   = req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
    rd_oor    = 32'(rd_addr) >= 32'(DEPTH);
    wr_oor    = 32'(wr_addr) >= 32'(DEPTH);
    tag_in    = '0;
    if (rd_fire) begin
      tag_in.valid = 1'b1;
      tag_in.id    = LUT_ID_WIDTH'(gnt_id);
      tag_in.oor   = rd_oor;
    end
  end

  // RAM controls are registered; out-of-range ops never strobe the RAM.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_rden    <= 1'b0;
      ram_wren    <= 1'b0;
    end else begin
      ram_wren <= wr_valid && !wr_oor;
      ram_rden <= rd_fire && !rd_oor;
      if (wr_valid && !wr_oor) begin
        ram_address <= wr_addr;
        ram_data    <= wr_data;
      end else if (rd_fire && !rd_oor) begin
        ram_address <= rd_addr;
      end
    end
  end

  // Tag pipe: one stage for the control register plus READ_LAT RAM stages,
  // so the last stage lines up with ram_q.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < TAG_DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Response decode from the aligned tag; data forced to 0 when out of range.
  always_comb begin
    rsp_valid = tag_q[TAG_DEPTH-1].valid;
    rsp_id    = ID_WIDTH'(tag_q[TAG_DEPTH-1].id);
    rsp_oor   = tag_q[TAG_DEPTH-1].oor;
    rsp_data  = (tag_q[TAG_DEPTH-1].valid && !tag_q[TAG_DEPTH-1].oor) ? ram_q : '0;
  end

`ifdef LUT_ARB_STATS_EN
  // Saturating activity counters with a synchronous clear.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_cnt    <= '0;
      stat_wr_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else if (stat_clr) begin
      stat_rd_cnt    <= '0;
      stat_wr_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (rd_fire && stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 1'b1;
      if (wr_valid && stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 1'b1;
      if (|(req_valid & ~gnt) && stat_stall_cnt != '1)
        stat_stall_cnt <= stat_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lut_access_arbiter.sv
// Bench for lut_access_arbiter: table of grant vectors, hand sequences for the
// multi-cycle cases, and a response scoreboard fed from observed handshakes.
module tb_lut_access_arbiter;

  localparam int NR    = 4;
  localparam int AW    = 12;
  localparam int DEPTH = 3072;
  localparam int RLAT  = 3;   // handshake cycle to response cycle

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]   req_ready;
  logic            wr_valid = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [31:0]     wr_data = '0;
  logic            wr_ready;
  logic [AW-1:0]   ram_address;
  logic [31:0]     ram_data;
  logic            ram_rden;
  logic            ram_wren;
  logic [31:0]     ram_q = '0;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_data;
  logic            rsp_oor;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lut_access_arbiter dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_address(ram_address), .ram_data(ram_data), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_q(ram_q),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_oor(rsp_oor)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // RAM with registered address and registered output (2 cycles from rden).
  logic [31:0]   ram_mem   [4096];
  logic [31:0]   model_mem [4096];
  logic [AW-1:0] ram_addr_r = '0;
  always @(posedge clock) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_addr_r <= ram_address;
    ram_q      <= ram_mem[ram_addr_r];
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [1:0] id;
    logic       oor;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  // Scoreboard: pop/compare responses, flag overdue ones, push new handshakes.
  always @(negedge clock) begin
    exp_t e;
    logic [AW-1:0] a;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_oor", 32'(rsp_oor), 32'(e.oor));
          chk("rsp_data", rsp_data, e.data);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        chk("rsp_missing", 32'(rsp_valid), 32'd1);
      end
      if (ram_rden && ram_wren) chk("rden_wren_excl", 32'd1, 32'd0);
      if (wr_valid && wr_ready && wr_addr < DEPTH) model_mem[wr_addr] = wr_data;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          a = req_addr[i*AW +: AW];
          e.cyc  = cyc + RLAT;
          e.id   = 2'(i);
          e.oor  = (a >= DEPTH);
          e.data = (a >= DEPTH) ? 32'd0 : model_mem[a];
          sbq.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_addr(int i, logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic [NR-1:0] rv;
    logic [NR-1:0] exp_rr;
    logic          exp_wr;
  } vec_t;
  vec_t vt[12];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i]   = 32'hA500_0000 ^ (i * 32'h0001_0101);
      model_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0101);
    end

    // pointer trace: 0 ->1 ->2 ->2(wr) ->1 ->0 ->0 ->2 ->3 ->1 ->2 ->3 ->0
    vt[0]  = '{1'b0, 12'd0,  32'h0,         4'b1111, 4'b0001, 1'b0};
    vt[1]  = '{1'b0, 12'd0,  32'h0,         4'b1111, 4'b0010, 1'b0};
    vt[2]  = '{1'b1, 12'd17, 32'h1234_5678, 4'b1111, 4'b0000, 1'b1};
    vt[3]  = '{1'b0, 12'd0,  32'h0,         4'b0001, 4'b0001, 1'b0};
    vt[4]  = '{1'b0, 12'd0,  32'h0,         4'b1001, 4'b1000, 1'b0};
    vt[5]  = '{1'b0, 12'd0,  32'h0,         4'b0000, 4'b0000, 1'b0};
    vt[6]  = '{1'b0, 12'd0,  32'h0,         4'b0110, 4'b0010, 1'b0};
    vt[7]  = '{1'b0, 12'd0,  32'h0,         4'b0101, 4'b0100, 1'b0};
    vt[8]  = '{1'b0, 12'd0,  32'h0,         4'b0101, 4'b0001, 1'b0};
    vt[9]  = '{1'b0, 12'd0,  32'h0,         4'b1111, 4'b0010, 1'b0};
    vt[10] = '{1'b0, 12'd0,  32'h0,         4'b1111, 4'b0100, 1'b0};
    vt[11] = '{1'b0, 12'd0,  32'h0,         4'b1111, 4'b1000, 1'b0};

    // 1. reset then idle
    repeat (3) tick();
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_ram_data", ram_data, 32'd0);
    chk("rst_rsp", {rsp_valid, rsp_oor, rsp_id, ram_rden, ram_wren, wr_ready}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
    end

    // table vectors
    for (int i = 0; i < NR; i++) set_addr(i, AW'(16 * i + 1));
    for (int k = 0; k < 12; k++) begin
      wr_valid  = vt[k].wv;
      wr_addr   = vt[k].wa;
      wr_data   = vt[k].wd;
      req_valid = vt[k].rv;
      @(negedge clock);
      chk($sformatf("vec%0d_req_ready", k), 32'(req_ready), 32'(vt[k].exp_rr));
      chk($sformatf("vec%0d_wr_ready", k), 32'(wr_ready), 32'(vt[k].exp_wr));
      tick();
    end
    wr_valid = 1'b0; req_valid = '0;
    repeat (5) tick();

    // 3. all requesters held, addr = id
    for (int i = 0; i < NR; i++) set_addr(i, AW'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("rr_all_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
    end
    req_valid = '0;
    repeat (5) tick();

    // 2. write then read-back with exact latency
    wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("t2_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0; set_addr(0, 12'd5); req_valid = 4'b0001;
    @(negedge clock);
    chk("t2_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    for (int k = 1; k <= RLAT; k++) begin
      @(negedge clock);
      if (k < RLAT) chk("t2_rsp_early", 32'(rsp_valid), 32'd0);
      else begin
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_id", 32'(rsp_id), 32'd0);
        chk("t2_rsp_data", rsp_data, 32'hDEAD_BEEF);
      end
      tick();
    end
    @(negedge clock);
    chk("t2_rsp_one_cycle", 32'(rsp_valid), 32'd0);
    tick();

    // 4. write blocks a read, read follows with the new data
    wr_valid = 1'b1; wr_addr = 12'd100; wr_data = 32'hCAFE_0100;
    set_addr(1, 12'd100); req_valid = 4'b0010;
    @(negedge clock);
    chk("t4_wr_ready", 32'(wr_ready), 32'd1);
    chk("t4_req_blocked", 32'(req_ready), 32'd0);
    tick();
    wr_valid = 1'b0;
    @(negedge clock);
    chk("t4_req1_next", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    repeat (5) tick();

    // 5. out-of-range read and write
    set_addr(2, 12'd3072); req_valid = 4'b0100;
    @(negedge clock);
    chk("t5_req_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    for (int k = 1; k <= RLAT; k++) begin
      @(negedge clock);
      chk("t5_no_rden", 32'(ram_rden), 32'd0);
      if (k == RLAT) begin
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t5_rsp_oor", 32'(rsp_oor), 32'd1);
        chk("t5_rsp_data", rsp_data, 32'd0);
      end
      tick();
    end
    wr_valid = 1'b1; wr_addr = 12'd4095; wr_data = 32'h5555_AAAA;
    @(negedge clock);
    chk("t5_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t5_no_wren", 32'(ram_wren), 32'd0);
      tick();
    end

    // 6. reset with two reads in flight
    for (int i = 0; i < NR; i++) set_addr(i, AW'(40 + i));
    req_valid = 4'b1111;
    repeat (2) tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    req_valid = 4'b1111;
    @(negedge clock);
    chk("t6_ptr_reset", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    repeat (6) tick();

    @(negedge clock);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
